dram_read_arb: RTL
==================

DRAM_READ_ARB -- requirements
Module: DramReadArb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of read requesters (2..8).
REQ-002 SHALL have parameter AW, default 32, DRAM address width.
REQ-003 SHALL have parameter DW, default 128, DRAM data width.
REQ-004 SHALL have parameter DEPTH, default 8, maximum outstanding reads (power of 2).
REQ-005 SHALL have ports: i_clk  in  1  single clock; i_rst  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: req_rdy  in  N_REQ  per-requester address valid; req_ack  out  N_REQ  address accepted; req_addr  in  N_REQ*AW  request addresses.
REQ-007 SHALL have ports: dramra_rdy  out  1; dramra_ack  in  1; dramra_addr  out  AW  DRAM read-address channel.
REQ-008 SHALL have ports: dramrd_rdy  in  1; dramrd_ack  out  1; dramrd_data  in  DW  DRAM read-data channel.
REQ-009 SHALL have ports: rsp_rdy  out  N_REQ  per-requester data valid; rsp_ack  in  N_REQ; rsp_data  out  DW  shared response data.
REQ-010 SHALL have port o_err  out  1  sticky flag for read data with no outstanding request.

Function
REQ-011 SHALL transfer on any channel exactly in a cycle with rdy&&ack high; a rdy, once high, holds its payload stable until ack.
REQ-012 SHALL register dramra_rdy/dramra_addr in a one-entry output slice; request-handshake-to-dramra_rdy latency is 1 cycle.
REQ-013 SHALL arbitrate only when the slice is empty or acked this cycle (dramra_rdy&&dramra_ack) and outstanding count < DEPTH.
REQ-014 SHALL grant round-robin: search starts at (last_grant+1) mod N_REQ; at most one req_ack per cycle; req_ack is combinational from req_rdy.
REQ-015 SHALL, on grant, load req_addr of the winner into the slice and push the winner ID into the tag FIFO in the same cycle.
REQ-016 SHALL sustain one grant per cycle when dramra_ack is held high and the FIFO is not full.
REQ-017 SHALL keep an outstanding count 0..DEPTH: +1 on grant, -1 on dramrd handshake, unchanged when both occur.
REQ-018 SHALL block grants while count==DEPTH even if a pop occurs the same cycle (no full bypass).
REQ-019 SHALL route responses in order: head ID h; rsp_rdy[h]=dramrd_rdy, other rsp_rdy low; dramrd_ack=rsp_ack[h]; rsp_data=dramrd_data, all combinational.
REQ-020 SHALL pop the tag FIFO on dramrd handshake; pointers wrap modulo DEPTH.
REQ-021 SHALL, when count==0 and dramrd_rdy is high, assert dramrd_ack (drain), drive all rsp_rdy low, and set o_err until reset.
REQ-022 SHALL keep last_grant unchanged in cycles with no grant.

Reset
REQ-023 SHALL, on i_rst low, asynchronously clear the slice (dramra_rdy=0, dramra_addr=0), FIFO pointers, count, o_err, and set last_grant=N_REQ-1.
REQ-024 SHALL discard all outstanding tags on reset mid-operation; req_ack, rsp_rdy and dramrd_ack evaluate to 0 while reset is asserted.

Structure
REQ-025 SHALL place default parameter constants and the requester-ID width constant (clog2 N_REQ) in the shared package.
REQ-026 SHALL implement the tag FIFO as one sub-module, TagFifo (parameters DEPTH, width; push, pop, head, count).
REQ-027 SHALL use the codebase rdyack macros for all four channel groups.

Verification
REQ-028 SHALL test: all four req_rdy high, dramra_ack always 1 -> grants in order 0,1,2,3,0, one per cycle; dramra_addr follows each grant 1 cycle later.
REQ-029 SHALL test: DEPTH=8, dramrd_rdy held 0, continuous requests -> exactly 8 grants, then req_ack stays 0; one dramrd handshake -> grant resumes the following cycle, not the same one.
REQ-030 SHALL test: grants to requesters 2,0,3 with responses D0,D1,D2 -> rsp_rdy[2] with D0, then rsp_rdy[0] with D1, then rsp_rdy[3] with D2.
REQ-031 SHALL test: rsp_ack[h]=0 for 5 cycles while dramrd_rdy=1 -> dramrd_ack=0 for 5 cycles, data held, FIFO not popped.
REQ-032 SHALL test: dramrd_rdy=1 with count=0 -> dramrd_ack=1, no rsp_rdy, o_err=1 persisting until i_rst low.
REQ-033 SHALL test: i_rst low with 3 reads outstanding and slice full -> dramra_rdy=0, count=0, next grant goes to requester 0.

Source files
------------

// File: rtl/dram_read_arb_pkg.sv
// Shared constants for the DRAM read arbiter: default sizing and requester-ID width.
package dram_read_arb_pkg;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_AW    = 32;
    localparam int unsigned DEF_DW    = 128;
    localparam int unsigned DEF_DEPTH = 8;

    // Width of a requester ID; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_ID_W = id_width(DEF_N_REQ);

endpackage

// File: rtl/dram_read_arb_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each outstanding DRAM read.
module dram_read_arb_tag_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage needs no reset; entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/dram_read_arb.sv
// Round-robin arbiter sharing one DRAM read port among N_REQ requesters,
// with in-order routing of read data back to the issuing requester.
module dram_read_arb
    import dram_read_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned AW    = DEF_AW,
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   req_rdy,
    output logic [N_REQ-1:0]   req_ack,
    input  logic [N_REQ*AW-1:0] req_addr,
    output logic               dramra_rdy,
    input  logic               dramra_ack,
    output logic [AW-1:0]      dramra_addr,
    input  logic               dramrd_rdy,
    output logic               dramrd_ack,
    input  logic [DW-1:0]      dramrd_data,
    output logic [N_REQ-1:0]   rsp_rdy,
    input  logic [N_REQ-1:0]   rsp_ack,
    output logic [DW-1:0]      rsp_data,
    output logic               o_err
);

    localparam int unsigned IW = id_width(N_REQ);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] addr_arr [N_REQ];
    logic [IW-1:0] last_grant;
    logic [IW-1:0] win_id;
    logic [IW-1:0] cand;
    logic [IW-1:0] head_id;
    logic [CW-1:0] out_cnt;
    logic          grant;
    logic          slot_free;
    logic          rd_pop;

    for (genvar g = 0; g < N_REQ; g++) begin : g_addr
        assign addr_arr[g] = req_addr[g*AW +: AW];
    end

    // Full check uses the registered count only, so a same-cycle pop cannot unblock a grant.
    assign slot_free = (!dramra_rdy || dramra_ack) && (out_cnt != CW'(DEPTH));

    // Round-robin pick starting just after the previous winner.
    always_comb begin
        req_ack = '0;
        win_id  = '0;
        grant   = 1'b0;
        cand    = '0;
        if (i_rst && slot_free) begin
            for (int unsigned k = 1; k <= N_REQ; k++) begin
                cand = IW'((32'(last_grant) + k) % N_REQ);
                if (!grant && req_rdy[cand]) begin
                    grant  = 1'b1;
                    win_id = cand;
                end
            end
        end
        if (grant) req_ack[win_id] = 1'b1;
    end

    // One-entry address slice toward DRAM; a grant reloads it even as it drains.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            dramra_rdy  <= 1'b0;
            dramra_addr <= '0;
        end else if (grant) begin
            dramra_rdy  <= 1'b1;
            dramra_addr <= addr_arr[win_id];
        end else if (dramra_ack) begin
            dramra_rdy  <= 1'b0;
        end
    end

    // Round-robin pointer moves only on a grant.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) last_grant <= IW'(N_REQ - 1);
        else if (grant) last_grant <= win_id;
    end

    dram_read_arb_tag_fifo #(
        .DEPTH (DEPTH),
        .W     (IW)
    ) u_tag_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst),
        .push      (grant),
        .push_data (win_id),
        .pop       (rd_pop),
        .head      (head_id),
        .count     (out_cnt)
    );

    // Steer read data to the oldest outstanding requester; drain stray data when none is outstanding.
    always_comb begin
        rsp_rdy    = '0;
        dramrd_ack = 1'b0;
        rsp_data   = dramrd_data;
        if (i_rst) begin
            if (out_cnt == '0) begin
                dramrd_ack = dramrd_rdy;
            end else begin
                rsp_rdy[head_id] = dramrd_rdy;
                dramrd_ack       = rsp_ack[head_id];
            end
        end
    end

    assign rd_pop = dramrd_rdy && dramrd_ack && (out_cnt != '0);

    // Sticky flag for read data that arrived with nothing outstanding.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) o_err <= 1'b0;
        else if (dramrd_rdy && (out_cnt == '0)) o_err <= 1'b1;
    end

endmodule
